semaforo_phase_scheduler: RTL and testbench

Phase scheduler for the intersection light controller. Sequences the six traffic phases plus an all-red preemption phase from a once-per-second tick. Latches pedestrian push-button requests and inserts the all-pedestrian phase only when one is pending. Drives the phase code, a load strobe and a seconds-remaining count to the light decoder and countdown display.

---
 rtl/semaforo_pkg.sv | 24 ++
 rtl/semaforo_tick_timer.sv | 26 ++
 rtl/semaforo_phase_scheduler.sv | 122 ++++++++++++
 tb/tb_semaforo_phase_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/semaforo_pkg.sv
// Shared phase codes, light codes and default durations for the intersection controller.
package semaforo_pkg;

   typedef enum logic [2:0] {
      PH_GA      = 3'd0,
      PH_YA      = 3'd1,
      PH_GB      = 3'd2,
      PH_YB      = 3'd3,
      PH_PED     = 3'd4,
      PH_PF      = 3'd5,
      PH_ALL_RED = 3'd6
   } phase_t;

   localparam logic [2:0] VERMELHO = 3'b100;
   localparam logic [2:0] AMARELO  = 3'b010;
   localparam logic [2:0] VERDE    = 3'b001;

   localparam int DEF_GREEN_A_T = 30;
   localparam int DEF_GREEN_B_T = 30;
   localparam int DEF_PED_T     = 15;
   localparam int DEF_YELLOW_T  = 3;
   localparam int DEF_CW        = 5;

endpackage

// File: rtl/semaforo_tick_timer.sv
// Per-phase seconds counter: loads duration-1, counts down on tick, stops at zero.
module semaforo_tick_timer #(
   parameter int            CW      = 5,
   parameter logic [CW-1:0] RST_VAL = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          tick,
   output logic [CW-1:0] cnt,
   output logic          zero
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= RST_VAL;
      else if (load)
         cnt <= load_val;
      else if (tick && cnt != '0)
         cnt <= cnt - CW'(1);
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/semaforo_phase_scheduler.sv
// Intersection phase sequencer with pedestrian latch and all-red preemption.
// Emergency preemption is compiled in only when SEMAFORO_EMERG_EN is defined.
module semaforo_phase_scheduler
   import semaforo_pkg::*;
#(
   parameter int GREEN_A_T = DEF_GREEN_A_T,
   parameter int GREEN_B_T = DEF_GREEN_B_T,
   parameter int PED_T     = DEF_PED_T,
   parameter int YELLOW_T  = DEF_YELLOW_T,
   parameter int CW        = DEF_CW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick,
   input  logic [9:0]    ped_req,
   input  logic          emerg,
   output logic [2:0]    phase,
   output logic          phase_load,
   output logic [CW-1:0] remaining,
   output logic          ped_pending,
   output logic [9:0]    ped_ack
);

`ifdef SEMAFORO_EMERG_EN
   localparam bit EMERG_EN = 1'b1;
`else
   localparam bit EMERG_EN = 1'b0;
`endif

   localparam logic [CW-1:0] GA_V  = CW'(GREEN_A_T - 1);
   localparam logic [CW-1:0] GB_V  = CW'(GREEN_B_T - 1);
   localparam logic [CW-1:0] PED_V = CW'(PED_T - 1);
   localparam logic [CW-1:0] YEL_V = CW'(YELLOW_T - 1);

   phase_t        state, nxt;
   logic [9:0]    pend, pend_nxt;
   logic          emg, expire, zero, hold, ack_now, load;
   logic [CW-1:0] load_val;

   function automatic logic [CW-1:0] dur_of(input phase_t p);
      case (p)
         PH_GA:   dur_of = GA_V;
         PH_GB:   dur_of = GB_V;
         PH_PED:  dur_of = PED_V;
         default: dur_of = YEL_V;
      endcase
   endfunction

   assign emg    = emerg & EMERG_EN;
   assign expire = tick & zero;

   always_comb begin
      nxt     = state;
      hold    = 1'b0;
      ack_now = 1'b0;
      case (state)
         PH_GA:  if (emg || expire) nxt = PH_YA;
         PH_GB:  if (emg || expire) nxt = PH_YB;
         PH_PED: if (emg || expire) nxt = PH_PF;
         PH_YA:  if (expire) nxt = emg ? PH_ALL_RED : PH_GB;
         PH_PF:  if (expire) nxt = emg ? PH_ALL_RED : PH_GA;
         PH_YB: begin
            if (expire) begin
               if (emg)
                  nxt = PH_ALL_RED;
               else if (pend != '0) begin
                  nxt     = PH_PED;
                  ack_now = 1'b1;
               end else
                  nxt = PH_GA;
            end
         end
`ifdef SEMAFORO_EMERG_EN
         // Held with a fresh yellow-length countdown for as long as emerg stays high.
         PH_ALL_RED: begin
            if (emg)
               hold = 1'b1;
            else if (expire)
               nxt = PH_GA;
         end
`endif
         default: nxt = PH_GA;
      endcase
   end

   assign load     = (nxt != state) | hold;
   assign load_val = hold ? YEL_V : dur_of(nxt);
   // Set wins over the clear on the cycle that enters PED.
   assign pend_nxt = (ack_now ? 10'd0 : pend) | ped_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= PH_GA;
         phase_load  <= 1'b0;
         pend        <= '0;
         ped_pending <= 1'b0;
         ped_ack     <= '0;
      end else begin
         state       <= nxt;
         phase_load  <= (nxt != state);
         pend        <= pend_nxt;
         ped_pending <= |pend_nxt;
         ped_ack     <= ack_now ? pend : 10'd0;
      end
   end

   assign phase = state;

   semaforo_tick_timer #(
      .CW      (CW),
      .RST_VAL (GA_V)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .tick     (tick),
      .cnt      (remaining),
      .zero     (zero)
   );

endmodule

// File: tb/tb_semaforo_phase_scheduler.sv
// Bench for semaforo_phase_scheduler: directed scenarios plus random traffic against a rule-level model.
module tb_semaforo_phase_scheduler;

   localparam int GA_T  = 30;
   localparam int GB_T  = 30;
   localparam int PED_T = 15;
   localparam int YEL_T = 3;
   localparam int CW    = 5;

`ifdef SEMAFORO_EMERG_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          tick;
   logic [9:0]    ped_req;
   logic          emerg;
   logic [2:0]    phase;
   logic          phase_load;
   logic [CW-1:0] remaining;
   logic          ped_pending;
   logic [9:0]    ped_ack;

   int errors = 0;
   int checks = 0;
   int load_cnt = 0;

   // Reference state: which phase, ticks left minus one, latched buttons, last-cycle strobes.
   int         m_phase, m_rem;
   logic [9:0] m_pend, m_ack;
   bit         m_load, m_pp;

   semaforo_phase_scheduler #(
      .GREEN_A_T (GA_T),
      .GREEN_B_T (GB_T),
      .PED_T     (PED_T),
      .YELLOW_T  (YEL_T),
      .CW        (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .ped_req     (ped_req),
      .emerg       (emerg),
      .phase       (phase),
      .phase_load  (phase_load),
      .remaining   (remaining),
      .ped_pending (ped_pending),
      .ped_ack     (ped_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   function automatic int duration(input int p);
      case (p)
         0:       return GA_T;
         2:       return GB_T;
         4:       return PED_T;
         default: return YEL_T;
      endcase
   endfunction

   task automatic model_reset();
      m_phase = 0;
      m_rem   = GA_T - 1;
      m_pend  = '0;
      m_ack   = '0;
      m_load  = 0;
      m_pp    = 0;
   endtask

   // Advance the reference by one clock given the inputs seen at that edge.
   task automatic model_clock(input bit t, input bit e, input logic [9:0] r);
      int  np;
      bit  fire, em, serve_ped;
      em        = EN && e;
      fire      = t && (m_rem == 0);
      np        = m_phase;
      serve_ped = 0;
      if (m_phase == 0 || m_phase == 2 || m_phase == 4) begin
         if (em || fire) np = m_phase + 1;
      end else if (m_phase == 1 || m_phase == 3 || m_phase == 5) begin
         if (fire) begin
            if (em)                np = 6;
            else if (m_phase == 1) np = 2;
            else if (m_phase == 5) np = 0;
            else if (m_pend != 0) begin np = 4; serve_ped = 1; end
            else                   np = 0;
         end
      end else if (m_phase == 6 && EN) begin
         if (!em && fire) np = 0;
      end else begin
         np = 0;
      end
      m_ack  = serve_ped ? m_pend : 10'd0;
      m_load = (np != m_phase);
      if (np != m_phase)            m_rem = duration(np) - 1;
      else if (m_phase == 6 && em)  m_rem = YEL_T - 1;
      else if (t && m_rem != 0)     m_rem = m_rem - 1;
      m_pend  = (serve_ped ? 10'd0 : m_pend) | r;
      m_pp    = (m_pend != 0);
      m_phase = np;
   endtask

   task automatic step();
      @(posedge clk);
      model_clock(tick, emerg, ped_req);
      #1;
      if (phase_load === 1'b1) load_cnt++;
      check("phase", 32'(phase), 32'(m_phase));
      check("remaining", 32'(remaining), 32'(m_rem));
      check("phase_load", 32'(phase_load), 32'(m_load));
      check("ped_pending", 32'(ped_pending), 32'(m_pp));
      check("ped_ack", 32'(ped_ack), 32'(m_ack));
   endtask

   task automatic run_until(input int p, input int maxc, input string tag);
      int n = 0;
      while (phase !== 3'(p) && n < maxc) begin
         step();
         n++;
      end
      check(tag, 32'(phase), 32'(p));
   endtask

   task automatic count_phase(input int p, input int want, input string tag);
      int n = 0;
      while (phase === 3'(p) && n < 100) begin
         step();
         n++;
      end
      check(tag, 32'(n), 32'(want));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_phase"}, 32'(phase), 32'd0);
      check({tag, "_remaining"}, 32'(remaining), 32'(GA_T - 1));
      check({tag, "_phase_load"}, 32'(phase_load), 32'd0);
      check({tag, "_ped_pending"}, 32'(ped_pending), 32'd0);
      check({tag, "_ped_ack"}, 32'(ped_ack), 32'd0);
   endtask

   initial begin
      rst = 1'b1; tick = 1'b0; ped_req = '0; emerg = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      model_reset();
      rst  = 1'b0;
      tick = 1'b1;

      // Plain loop with a tick every clock: four phase changes per 66 cycles.
      load_cnt = 0;
      repeat (66) step();
      check("loop_loads", 32'(load_cnt), 32'd4);
      check("loop_end_phase", 32'(phase), 32'd0);
      check("loop_end_remaining", 32'(remaining), 32'(GA_T - 1));

      // Single button press during GA gets a PED/PF insertion.
      ped_req = 10'h004;
      step();
      ped_req = '0;
      check("ped_pending_set", 32'(ped_pending), 32'd1);
      run_until(4, 200, "reach_ped");
      check("ped_ack_p3", 32'(ped_ack), 32'h004);
      check("ped_pending_clr", 32'(ped_pending), 32'd0);
      count_phase(4, PED_T, "ped_len");
      count_phase(5, YEL_T, "pf_len");
      check("after_pf", 32'(phase), 32'd0);

      // Button held across the PED entry edge stays latched.
      ped_req = 10'h001;
      run_until(4, 200, "reach_ped_held");
      check("ped_ack_held", 32'(ped_ack[0]), 32'd1);
      check("ped_pending_held", 32'(ped_pending), 32'd1);
      ped_req = '0;
      run_until(0, 100, "back_to_ga");
      run_until(4, 200, "ped_again");
      run_until(0, 100, "back_to_ga2");

      // Emergency in GA with 21 seconds left.
      begin
         int n = 0;
         while (!(phase === 3'd0 && remaining === CW'(20)) && n < 200) begin
            step();
            n++;
         end
         check("ga_rem20", 32'(remaining), 32'd20);
      end
      emerg = 1'b1;
      step();
      check("emerg_ga_react", 32'(phase), EN ? 32'd1 : 32'd0);
      repeat (52) step();
      emerg = 1'b0;
      run_until(0, 100, "emerg_recover");
      check("emerg_recover_rem", 32'(remaining), 32'(GA_T - 1));

      // Emergency during PED with a request latched after PED entry.
      ped_req = 10'h002;
      step();
      ped_req = '0;
      run_until(4, 200, "reach_ped_e");
      check("ped_ack_e", 32'(ped_ack), 32'h002);
      ped_req = 10'h200;
      step();
      ped_req = '0;
      emerg = 1'b1;
      repeat (10) step();
      emerg = 1'b0;
      run_until(0, 100, "ped_emerg_ga");
      check("pend_survives", 32'(ped_pending), 32'd1);
      run_until(4, 200, "ped_reinserted");
      check("ped_ack_reins", 32'(ped_ack), 32'h200);

      // Random traffic against the reference model.
      for (int i = 0; i < 3000; i++) begin
         tick    = ($urandom_range(0, 3) != 0);
         ped_req = ($urandom_range(0, 19) == 0) ? 10'($urandom) : 10'd0;
         if ($urandom_range(0, 99) == 0) emerg = ~emerg;
         step();
      end

      // Asynchronous reset in the middle of GB with requests pending.
      tick = 1'b1; emerg = 1'b0; ped_req = '0;
      run_until(2, 300, "reach_gb");
      repeat (5) step();
      ped_req = 10'h3FF;
      step();
      ped_req = '0;
      check("pend_before_rst", 32'(ped_pending), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_reset_values("async_rst");
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      step();
      check("no_load_on_release", 32'(phase_load), 32'd0);
      repeat (40) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench did not finish");
   end

endmodule
